sdram_port_arb: RTL and testbench

- Shares the single byte-wide CPU port of the SDRAM controller (addr/din/dout/we/rd/ram_busy) between NCLIENT requesters: client 0 is the Z80 CPU path; the others are DMA-style clients such as the disk/tape loader and the ROM uploader.
- Converts each client's level request/ack handshake into the controller's edge-triggered rd/we strobes.
- Detects completion through ram_busy, including the cache-hit case where ram_busy never rises.
- Sits between the client muxing in the top level and the sdram instance.

---
 rtl/sdram_port_arb_pkg.sv | 25 ++
 rtl/sdram_port_arb_if.sv | 48 ++++
 rtl/sdram_port_arb_rr_pick.sv | 35 +++
 rtl/sdram_port_arb.sv | 187 ++++++++++++++++++
 tb/tb_sdram_port_arb.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_port_arb_pkg.sv
// Shared types and constants for the SDRAM CPU-port arbiter.
package sdram_arb_pkg;

  // Arbiter transaction phases
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Ceiling log2, used to size client indices and the round-robin pointer
  function automatic int clog2_nclient(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Index/pointer width sized for the largest supported client count (8)
  localparam int PTR_W = clog2_nclient(8);

endpackage

// File: rtl/sdram_port_arb_if.sv
// Bus bundles around the arbiter: the client-side request/ack bus and the
// controller-side byte port.

// Requesters drive the master side, the arbiter is the slave
interface sdram_arb_client_if #(
  parameter int NCLIENT = 3,
  parameter int AW      = 25
);
  logic [NCLIENT-1:0]    req;
  logic [NCLIENT-1:0]    req_we;
  logic [NCLIENT*AW-1:0] req_addr;
  logic [NCLIENT*8-1:0]  req_din;
  logic [NCLIENT-1:0]    ack;
  logic                  ack_err;
  logic [7:0]            rdata;

  modport master (
    output req, req_we, req_addr, req_din,
    input  ack, ack_err, rdata
  );

  modport slave (
    input  req, req_we, req_addr, req_din,
    output ack, ack_err, rdata
  );
endinterface

// The arbiter drives the master side, the SDRAM controller is the slave
interface sdram_arb_ram_if #(
  parameter int AW = 25
);
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic          ram_we;
  logic          ram_rd;
  logic [7:0]    ram_dout;
  logic          ram_busy;

  modport master (
    output ram_addr, ram_din, ram_we, ram_rd,
    input  ram_dout, ram_busy
  );

  modport slave (
    input  ram_addr, ram_din, ram_we, ram_rd,
    output ram_dout, ram_busy
  );
endinterface

// File: rtl/sdram_port_arb_rr_pick.sv
// Combinational round-robin selector: finds the first set request at or after
// the pointer, wrapping. Entry j of req_i stands for client j+1, so the
// pointer and the returned index are client numbers (1..N).
module rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  // Scan the N entries starting at the pointer and keep the first hit
  always_comb begin
    int base;
    int c;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    c       = 0;
    base    = (int'(ptr_i) >= 1 && int'(ptr_i) <= N) ? int'(ptr_i) - 1 : 0;
    for (int k = 0; k < N; k++) begin
      c = (base + k) % N;
      if (!any_o && req_i[c]) begin
        any_o      = 1'b1;
        grant_o[c] = 1'b1;
        idx_o      = PTR_W'(c + 1);
      end
    end
  end

endmodule

// File: rtl/sdram_port_arb.sv
// Shares the SDRAM controller's byte-wide CPU port between NCLIENT requesters.
// Client 0 (Z80) has fixed priority; the rest rotate. Level req/ack handshakes
// become rd/we strobes, completion is seen on ram_busy falling (or never
// rising on a cache hit), and a watchdog aborts a stuck transaction.
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int NCLIENT = 3,
  parameter int AW      = 25,
  parameter int TO_W    = 8
) (
  input  logic             clk_i,
  input  logic             init_n_i,
  sdram_arb_client_if.slave cli,
  sdram_arb_ram_if.master   ram,
  output logic             timeout_o,
  output logic             active_o
);

  arb_state_t         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gnt_q, gnt_d;
  logic [TO_W-1:0]    wdog_q, wdog_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [7:0]         din_q, din_d;
  logic               we_q, we_d;
  logic               rd_q, rd_d;
  logic [NCLIENT-1:0] ack_q, ack_d;
  logic               ack_err_q, ack_err_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               timeout_q, timeout_d;
  logic               active_q, active_d;

  logic [NCLIENT-2:0] rr_grant;
  logic [PTR_W-1:0]   rr_idx;
  logic               rr_any;

  logic [NCLIENT-1:0] win_oh;
  logic [PTR_W-1:0]   win_idx;
  logic               win_any;
  logic               sel_we;
  logic [AW-1:0]      sel_addr;
  logic [7:0]         sel_din;
  logic [NCLIENT-1:0] gnt_oh;

  rr_pick #(
    .N (NCLIENT - 1)
  ) u_rr_pick (
    .req_i   (cli.req[NCLIENT-1:1]),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant),
    .idx_o   (rr_idx),
    .any_o   (rr_any)
  );

  assign win_any = cli.req[0] | rr_any;
  assign win_idx = cli.req[0] ? '0 : rr_idx;
  assign win_oh  = cli.req[0] ? NCLIENT'(1) : {rr_grant, 1'b0};

  // Mux the winning client's direction, address and write data
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    for (int i = 0; i < NCLIENT; i++) begin
      if (win_oh[i]) begin
        sel_we   = cli.req_we[i];
        sel_addr = cli.req_addr[i*AW +: AW];
        sel_din  = cli.req_din[i*8 +: 8];
      end
    end
  end

  // One-hot form of the stored grant index, for the ack pulse
  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < NCLIENT; i++) begin
      gnt_oh[i] = (int'(gnt_q) == i);
    end
  end

  // Next-state and registered-output logic for the transaction FSM
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    wdog_d    = wdog_q;
    addr_d    = addr_q;
    din_d     = din_q;
    we_d      = we_q;
    rd_d      = rd_q;
    ack_d     = '0;
    ack_err_d = 1'b0;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    active_d  = active_q;

    case (state_q)
      IDLE: begin
        if (win_any) begin
          gnt_d    = win_idx;
          addr_d   = sel_addr;
          din_d    = sel_din;
          we_d     = sel_we;
          rd_d     = ~sel_we;
          active_d = 1'b1;
          state_d  = GUARD;
          if (win_idx != '0) begin
            if (int'(win_idx) >= NCLIENT - 1) ptr_d = PTR_W'(1);
            else                              ptr_d = win_idx + PTR_W'(1);
          end
        end
      end
      GUARD: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!ram.ram_busy) begin
          if (!we_q) rdata_d = ram.ram_dout;
          we_d    = 1'b0;
          rd_d    = 1'b0;
          ack_d   = gnt_oh;
          state_d = DONE;
        end else if (wdog_q == '1) begin
          we_d      = 1'b0;
          rd_d      = 1'b0;
          ack_d     = gnt_oh;
          ack_err_d = 1'b1;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          wdog_d = wdog_q + TO_W'(1);
        end
      end
      DONE: begin
        active_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!init_n_i) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_W'(1);
      gnt_q     <= '0;
      wdog_q    <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      we_q      <= 1'b0;
      rd_q      <= 1'b0;
      ack_q     <= '0;
      ack_err_q <= 1'b0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      wdog_q    <= wdog_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      ack_q     <= ack_d;
      ack_err_q <= ack_err_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      active_q  <= active_d;
    end
  end

  assign ram.ram_addr = addr_q;
  assign ram.ram_din  = din_q;
  assign ram.ram_we   = we_q;
  assign ram.ram_rd   = rd_q;
  assign cli.ack      = ack_q;
  assign cli.ack_err  = ack_err_q;
  assign cli.rdata    = rdata_q;
  assign timeout_o    = timeout_q;
  assign active_o     = active_q;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb with a small SDRAM controller model that
// raises ram_busy for a programmable number of cycles after each strobe edge.
module tb_sdram_port_arb;

  localparam int NC = 3;
  localparam int AW = 25;

  logic clk;
  logic init_n;
  logic timeout;
  logic active;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int   busyCnt = 0;
  int   missLat = 0;
  logic busyForever = 1'b0;
  logic prevStrobe = 1'b0;

  sdram_arb_client_if #(.NCLIENT(NC), .AW(AW)) cli ();
  sdram_arb_ram_if    #(.AW(AW))               ram ();

  sdram_port_arb #(
    .NCLIENT (NC),
    .AW      (AW),
    .TO_W    (8)
  ) dut (
    .clk_i     (clk),
    .init_n_i  (init_n),
    .cli       (cli),
    .ram       (ram),
    .timeout_o (timeout),
    .active_o  (active)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to measure grant-to-ack latency
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: a rising rd/we strobe starts a busy window of missLat cycles
  always @(posedge clk) begin
    prevStrobe <= ram.ram_rd | ram.ram_we;
    if ((ram.ram_rd | ram.ram_we) && !prevStrobe) busyCnt <= missLat;
    else if (busyCnt > 0)                         busyCnt <= busyCnt - 1;
  end
  assign ram.ram_busy = busyForever | (busyCnt > 0);

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int c, input logic we, input logic [AW-1:0] addr,
                               input logic [7:0] din);
    cli.req_we[c]             = we;
    cli.req_addr[c*AW +: AW]  = addr;
    cli.req_din[c*8 +: 8]     = din;
    cli.req[c]                = 1'b1;
  endtask

  task automatic waitGrant(input string tag, input int limit, output int gCyc,
                           output logic [AW-1:0] gAddr);
    logic seen;
    seen  = 1'b0;
    gCyc  = 0;
    gAddr = '0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (ram.ram_rd || ram.ram_we) begin
        seen  = 1'b1;
        gCyc  = cyc;
        gAddr = ram.ram_addr;
        break;
      end
    end
    checkOutput({tag, "_grant_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic waitAck(input string tag, input int limit, input int gCyc,
                         input logic [AW-1:0] gAddr, output int idx, output int lat,
                         output logic addrMoved, output logic sawRd);
    logic seen;
    seen      = 1'b0;
    idx       = -1;
    lat       = -1;
    addrMoved = 1'b0;
    sawRd     = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (ram.ram_addr !== gAddr) addrMoved = 1'b1;
      if (ram.ram_rd) sawRd = 1'b1;
      if (cli.ack != '0) begin
        seen = 1'b1;
        lat  = cyc - gCyc;
        for (int i = 0; i < NC; i++) if (cli.ack[i]) idx = i;
        break;
      end
    end
    checkOutput({tag, "_ack_seen"}, 64'(seen), 64'd1);
  endtask

  int expOrder [10] = '{0, 0, 0, 0, 0, 0, 1, 2, 1, 2};

  initial begin
    int gCyc, idx, lat;
    logic [AW-1:0] gAddr;
    logic moved, rdSeen;

    init_n       = 1'b0;
    cli.req      = '0;
    cli.req_we   = '0;
    cli.req_addr = '0;
    cli.req_din  = '0;
    ram.ram_dout = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_ack",     64'(cli.ack),      64'h0);
    checkOutput("rst_rd_we",   64'({ram.ram_rd, ram.ram_we}), 64'h0);
    checkOutput("rst_addr",    64'(ram.ram_addr), 64'h0);
    checkOutput("rst_rdata",   64'(cli.rdata),    64'h0);
    checkOutput("rst_active",  64'(active),       64'h0);
    checkOutput("rst_timeout", 64'(timeout),      64'h0);
    init_n = 1'b1;
    @(negedge clk);

    // 1: cache-hit read on client 0
    $display("[TB] test 1: cache-hit read");
    missLat      = 0;
    ram.ram_dout = 8'hA5;
    applyStimulus(0, 1'b0, 25'h0001235, 8'h00);
    waitGrant("t1", 20, gCyc, gAddr);
    checkOutput("t1_rd_at_grant", 64'({ram.ram_rd, ram.ram_we}), 64'b10);
    checkOutput("t1_addr",        64'(ram.ram_addr), 64'h0001235);
    checkOutput("t1_active",      64'(active), 64'h1);
    waitAck("t1", 20, gCyc, gAddr, idx, lat, moved, rdSeen);
    cli.req[0] = 1'b0;
    checkOutput("t1_idx",     64'(idx), 64'd0);
    checkOutput("t1_latency", 64'(lat), 64'd2);
    checkOutput("t1_rdata",   64'(cli.rdata), 64'hA5);
    checkOutput("t1_rd_low",  64'(ram.ram_rd), 64'h0);
    checkOutput("t1_ack_err", 64'(cli.ack_err), 64'h0);
    repeat (2) @(negedge clk);
    checkOutput("t1_idle_active", 64'(active), 64'h0);
    checkOutput("t1_ack_pulse",   64'(cli.ack), 64'h0);

    // 2: miss read on client 1, busy for 9 cycles
    $display("[TB] test 2: miss read");
    missLat      = 9;
    ram.ram_dout = 8'h3C;
    applyStimulus(1, 1'b0, 25'h1FFFFFE, 8'h00);
    waitGrant("t2", 20, gCyc, gAddr);
    checkOutput("t2_addr", 64'(ram.ram_addr), 64'h1FFFFFE);
    waitAck("t2", 40, gCyc, gAddr, idx, lat, moved, rdSeen);
    cli.req[1] = 1'b0;
    checkOutput("t2_idx",     64'(idx), 64'd1);
    checkOutput("t2_latency", 64'(lat), 64'd11);
    checkOutput("t2_ack_err", 64'(cli.ack_err), 64'h0);
    checkOutput("t2_rdata",   64'(cli.rdata), 64'h3C);
    repeat (2) @(negedge clk);

    // 3: write on client 2; request fields change after grant
    $display("[TB] test 3: write");
    missLat      = 4;
    ram.ram_dout = 8'hEE;
    applyStimulus(2, 1'b1, 25'h0400000, 8'h5A);
    waitGrant("t3", 20, gCyc, gAddr);
    checkOutput("t3_we",  64'({ram.ram_rd, ram.ram_we}), 64'b01);
    checkOutput("t3_din", 64'(ram.ram_din), 64'h5A);
    checkOutput("t3_addr", 64'(ram.ram_addr), 64'h0400000);
    cli.req_addr[2*AW +: AW] = 25'h0123456;
    cli.req_din[2*8 +: 8]    = 8'hFF;
    waitAck("t3", 40, gCyc, gAddr, idx, lat, moved, rdSeen);
    cli.req[2] = 1'b0;
    checkOutput("t3_idx",          64'(idx), 64'd2);
    checkOutput("t3_latency",      64'(lat), 64'd6);
    checkOutput("t3_addr_stable",  64'(moved), 64'h0);
    checkOutput("t3_no_rd",        64'(rdSeen), 64'h0);
    checkOutput("t3_din_held",     64'(ram.ram_din), 64'h5A);
    checkOutput("t3_we_low",       64'(ram.ram_we), 64'h0);
    checkOutput("t3_rdata_kept",   64'(cli.rdata), 64'h3C);
    repeat (2) @(negedge clk);

    // 4: all clients requesting: client 0 dominates, then 1 and 2 rotate
    $display("[TB] test 4: priority and rotation");
    missLat      = 0;
    ram.ram_dout = 8'h11;
    applyStimulus(0, 1'b0, 25'h0000010, 8'h00);
    applyStimulus(1, 1'b0, 25'h0000020, 8'h00);
    applyStimulus(2, 1'b0, 25'h0000030, 8'h00);
    for (int t = 0; t < 10; t++) begin
      waitAck("t4", 20, cyc, ram.ram_addr, idx, lat, moved, rdSeen);
      checkOutput($sformatf("t4_order%0d", t), 64'(idx), 64'(expOrder[t]));
      if (t == 5) cli.req[0] = 1'b0;
    end
    cli.req = '0;
    repeat (2) @(negedge clk);
    checkOutput("t4_idle_active", 64'(active), 64'h0);
    checkOutput("t4_rdata",       64'(cli.rdata), 64'h11);

    // 5: controller stuck busy; watchdog aborts, then normal service resumes
    $display("[TB] test 5: watchdog");
    busyForever  = 1'b1;
    ram.ram_dout = 8'h77;
    applyStimulus(1, 1'b0, 25'h0000040, 8'h00);
    waitGrant("t5", 20, gCyc, gAddr);
    waitAck("t5", 400, gCyc, gAddr, idx, lat, moved, rdSeen);
    cli.req[1]  = 1'b0;
    busyForever = 1'b0;
    checkOutput("t5_idx",     64'(idx), 64'd1);
    checkOutput("t5_latency", 64'(lat), 64'd257);
    checkOutput("t5_ack_err", 64'(cli.ack_err), 64'h1);
    checkOutput("t5_timeout", 64'(timeout), 64'h1);
    checkOutput("t5_rdata",   64'(cli.rdata), 64'h11);
    checkOutput("t5_rd_low",  64'(ram.ram_rd), 64'h0);
    ram.ram_dout = 8'h99;
    applyStimulus(2, 1'b0, 25'h0000050, 8'h00);
    waitGrant("t5b", 20, gCyc, gAddr);
    waitAck("t5b", 20, gCyc, gAddr, idx, lat, moved, rdSeen);
    cli.req[2] = 1'b0;
    checkOutput("t5b_idx",     64'(idx), 64'd2);
    checkOutput("t5b_latency", 64'(lat), 64'd2);
    checkOutput("t5b_ack_err", 64'(cli.ack_err), 64'h0);
    checkOutput("t5b_rdata",   64'(cli.rdata), 64'h99);
    checkOutput("t5b_timeout_sticky", 64'(timeout), 64'h1);
    repeat (2) @(negedge clk);

    // 6: reset while waiting on a miss; pointer restarts at client 1
    $display("[TB] test 6: reset mid-transaction");
    missLat = 20;
    applyStimulus(1, 1'b0, 25'h0000060, 8'h00);
    waitGrant("t6", 20, gCyc, gAddr);
    repeat (4) @(negedge clk);
    init_n = 1'b0;
    applyStimulus(2, 1'b0, 25'h0000070, 8'h00);
    @(negedge clk);
    checkOutput("t6_rd_we",  64'({ram.ram_rd, ram.ram_we}), 64'h0);
    checkOutput("t6_ack",    64'(cli.ack), 64'h0);
    checkOutput("t6_active", 64'(active), 64'h0);
    checkOutput("t6_timeout_cleared", 64'(timeout), 64'h0);
    missLat = 0;
    init_n  = 1'b1;
    waitGrant("t6b", 20, gCyc, gAddr);
    checkOutput("t6b_addr", 64'(ram.ram_addr), 64'h0000060);
    waitAck("t6b", 20, gCyc, gAddr, idx, lat, moved, rdSeen);
    cli.req = '0;
    checkOutput("t6b_idx",     64'(idx), 64'd1);
    checkOutput("t6b_latency", 64'(lat), 64'd2);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
